// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared definitions for the APB master bridge. This package
//                holds the transfer FSM state encoding, the default bus
//                widths, the registered response record and the saturating
//                increment used by the error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default geometry of the bridge
    localparam int APB_ADDR_W_DEF     = 16;
    localparam int APB_DATA_W_DEF     = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int ERR_CNT_W          = 8;

    // Transfer FSM: one outstanding APB transfer at a time
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Response captured at the end of ACCESS and held through RESP
    typedef struct packed {
        logic [APB_DATA_W_DEF-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Wait-state counter for the APB ACCESS phase. Cleared before
//                each ACCESS phase, counts ACCESS cycles in which the slave
//                holds PREADY low, and flags expiry in the cycle that would
//                bring the count to TIMEOUT_CYCLES.
//  Ports       : clk_i     - clock (rising edge)
//                rst_n_i   - synchronous active-low reset
//                clear_i   - return count to zero
//                enable_i  - count this cycle (ACCESS with PREADY low)
//                expire_o  - this enabled cycle is the TIMEOUT_CYCLES-th one
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is raised while the limit-reaching cycle is still in progress so
    // the FSM can abort on that very edge. Because enable_i already requires
    // PREADY low, a PREADY=1 in that cycle never sees expiry and completes.
    assign expire_o = enable_i && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Converts a valid/ready command channel into single APB
//                transfers (SETUP then ACCESS) and returns each result on a
//                valid/ready response channel. Slaves that stretch ACCESS
//                beyond TIMEOUT_CYCLES wait states are abandoned and an error
//                response flagged as a timeout is returned instead.
//  Ports       : PCLK, PRESETn             - clock, sync active-low reset
//                cmd_valid/ready/write/addr/wdata - request channel
//                rsp_valid/ready/rdata/err/timeout - response channel
//                PADDR..PSLVERR            - APB master interface
//                err_cnt                   - saturating count of error responses
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_W_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    // Command channel
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    // Response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    // APB master
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    // Status
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    // Byte-lane bits forced low: every transfer is a word access
    localparam logic [APB_ADDR_WIDTH-1:0] C_LANE_MASK = APB_ADDR_WIDTH'(3);

    apb_state_e                state_q;
    apb_state_e                state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    apb_rsp_t                  rsp_q;
    apb_rsp_t                  rsp_d;
    logic [ERR_CNT_W-1:0]      err_cnt_q;

    logic                      cmd_fire;
    logic                      rsp_fire;
    logic                      timer_clear;
    logic                      timer_en;
    logic                      timer_expire;
    logic                      psel_d;
    logic                      penable_d;

    // Held low while PRESETn is asserted so no command can be taken in reset
    assign cmd_ready   = (state_q == ST_IDLE) && PRESETn;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_fire    = rsp_valid && rsp_ready;

    // SETUP always precedes ACCESS, so clearing there starts every ACCESS at 0
    assign timer_clear = (state_q == ST_SETUP);
    assign timer_en    = (state_q == ST_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (PCLK),
        .rst_n_i  (PRESETn),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    // ------------------------------------------------------------------
    // Transfer FSM: next state, response capture and APB strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                psel_d  = 1'b1;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                if (PREADY) begin
                    // Write responses carry no data
                    rsp_d.rdata   = pwrite_q ? '0 : APB_DATA_W_DEF'(PRDATA);
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = ST_RESP;
                end else if (timer_expire) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
        end
    end

    // ------------------------------------------------------------------
    // Command capture: address/control/data are loaded only on acceptance
    // and therefore stay stable for the whole SETUP/ACCESS sequence.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (cmd_fire) begin
            paddr_q  <= cmd_addr & ~C_LANE_MASK;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
        end
    end

    // Counted at the response handshake so a response is counted exactly once
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            err_cnt_q <= '0;
        end else if (rsp_fire && rsp_q.err) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSEL        = psel_d;
    assign PENABLE     = penable_d;

    // Response storage is sized by the package data width; the cast adapts
    // it to this instance's bus width.
    assign rsp_rdata   = APB_DATA_WIDTH'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Directed testbench for apb_master_bridge with a small APB
//                slave stub (programmable wait states and PSLVERR, one
//                read/write register at 0x10, read-only status at 0x00).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int          AW        = 16;
    localparam int          DW        = 32;
    localparam int          TO        = 16;
    localparam logic [31:0] STATUS32B = 32'h9c4e9a31;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [7:0]    err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .err_cnt     (err_cnt)
    );

    // ------------------------------------------------------------------
    // Slave stub: PREADY goes high after stub_wait low ACCESS cycles
    // ------------------------------------------------------------------
    logic [31:0] reg10;
    int          acc_cnt   = 0;
    int          stub_wait = 0;
    logic        stub_err  = 1'b0;

    assign PREADY  = PSEL && PENABLE && (acc_cnt >= stub_wait);
    assign PSLVERR = PREADY && stub_err;

    always_comb begin
        PRDATA = '0;
        if (PSEL && PENABLE && PREADY && !PWRITE) begin
            case (PADDR)
                16'h0000: PRDATA = STATUS32B;
                16'h0010: PRDATA = reg10;
                default:  PRDATA = 32'hDEADBEEF;
            endcase
        end
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR && (PADDR == 16'h0010))
            reg10 <= PWDATA;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    logic [AW-1:0] snap_paddr;
    logic [DW-1:0] snap_pwdata;
    logic          snap_pwrite;
    int            lat;

    // Issues one command and returns with rsp_valid seen (or the bound hit).
    // lat counts cycles after the accept edge: SETUP is 1, so zero-wait gives 3.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int wt, input logic e);
        int guard;
        stub_wait = wt;
        stub_err  = e;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        cmd_valid   = 1'b0;
        snap_paddr  = PADDR;
        snap_pwdata = PWDATA;
        snap_pwrite = PWRITE;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_flags", 64'({rsp_err, rsp_timeout}), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        PRESETn = 1'b1;
        #1;
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // Zero-wait write 0x10 = 0x11223344, cycle by cycle
        stub_wait = 0;
        stub_err  = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0010;
        cmd_wdata = 32'h11223344;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_strobes", 64'({PSEL, PENABLE}), 64'b10);
        check("wr_setup_paddr", 64'(PADDR), 64'h10);
        check("wr_setup_pwrite", 64'(PWRITE), 64'd1);
        check("wr_setup_pwdata", 64'(PWDATA), 64'h11223344);
        check("wr_setup_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("wr_access_strobes", 64'({PSEL, PENABLE}), 64'b11);
        check("wr_access_stable", 64'({PADDR, PWRITE, PWDATA}), {15'd0, 16'h0010, 1'b1, 32'h11223344});
        check("wr_access_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("wr_resp_valid", 64'(rsp_valid), 64'd1);
        check("wr_resp_strobes", 64'({PSEL, PENABLE}), 64'b00);
        check("wr_resp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_resp_flags", 64'({rsp_err, rsp_timeout}), 64'd0);
        tick();
        check("wr_done_rsp_valid", 64'(rsp_valid), 64'd0);
        check("wr_done_cmd_ready", 64'(cmd_ready), 64'd1);

        // Readback of 0x10
        xfer(1'b0, 16'h0010, 32'h0, 0, 1'b0);
        check("rd10_lat", 64'(lat), 64'd3);
        check("rd10_rdata", 64'(rsp_rdata), 64'h11223344);
        check("rd10_err", 64'(rsp_err), 64'd0);
        tick();

        // Unaligned read of status: lanes forced to 0, PWDATA zero on reads
        xfer(1'b0, 16'h0003, 32'hFFFFFFFF, 0, 1'b0);
        check("rd00_paddr", 64'(snap_paddr), 64'h0);
        check("rd00_pwdata", 64'(snap_pwdata), 64'h0);
        check("rd00_pwrite", 64'(snap_pwrite), 64'd0);
        check("rd00_lat", 64'(lat), 64'd3);
        check("rd00_rdata", 64'(rsp_rdata), 64'(STATUS32B));
        check("rd00_err", 64'(rsp_err), 64'd0);
        tick();

        // Three wait states ending in PSLVERR
        xfer(1'b1, 16'h0020, 32'h55AA55AA, 3, 1'b1);
        check("slverr_lat", 64'(lat), 64'd6);
        check("slverr_flags", 64'({rsp_err, rsp_timeout}), 64'b10);
        tick();
        check("slverr_err_cnt", 64'(err_cnt), 64'd1);

        // PREADY rises on the 16th ACCESS cycle: normal completion
        xfer(1'b0, 16'h0010, 32'h0, TO - 1, 1'b0);
        check("edge_lat", 64'(lat), 64'd18);
        check("edge_flags", 64'({rsp_err, rsp_timeout}), 64'b00);
        check("edge_rdata", 64'(rsp_rdata), 64'h11223344);
        tick();

        // PREADY low for 20 cycles: abort after 16 ACCESS cycles
        xfer(1'b0, 16'h0010, 32'h0, 20, 1'b0);
        check("to_lat", 64'(lat), 64'd18);
        check("to_flags", 64'({rsp_err, rsp_timeout}), 64'b11);
        check("to_rdata", 64'(rsp_rdata), 64'd0);
        check("to_strobes", 64'({PSEL, PENABLE}), 64'b00);
        tick();
        check("to_err_cnt", 64'(err_cnt), 64'd2);

        // Response back-pressure with cmd_valid held high throughout
        stub_wait = 0;
        stub_err  = 1'b0;
        rsp_ready = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 32'h0;
        cmd_valid = 1'b1;
        tick();
        check("bp_setup_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        tick();
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_rdata", 64'(rsp_rdata), 64'(STATUS32B));
            check("bp_hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_hold_psel", 64'(PSEL), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_done_rsp_valid", 64'(rsp_valid), 64'd0);
        check("bp_done_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_write = 1'b1;
        cmd_addr  = 16'h0010;
        cmd_wdata = 32'hCAFEF00D;
        tick();
        cmd_valid = 1'b0;
        check("bp_next_strobes", 64'({PSEL, PENABLE}), 64'b10);
        check("bp_next_cmd", 64'({PADDR, PWRITE, PWDATA}), {15'd0, 16'h0010, 1'b1, 32'hCAFEF00D});
        tick();
        tick();
        check("bp_next_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();

        // Reset pulsed during ACCESS
        stub_wait = 10;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0010;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mr_access_strobes", 64'({PSEL, PENABLE}), 64'b11);
        PRESETn = 1'b0;
        tick();
        check("mr_strobes", 64'({PSEL, PENABLE}), 64'b00);
        check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mr_err_cnt", 64'(err_cnt), 64'd0);
        check("mr_cmd_ready", 64'(cmd_ready), 64'd0);
        PRESETn = 1'b1;
        #1;
        check("mr_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_rsp", 64'({rsp_valid, PSEL}), 64'd0);
        end

        // err_cnt saturation
        for (int i = 0; i < 254; i++) begin
            xfer(1'b0, 16'h0000, 32'h0, 0, 1'b1);
            tick();
        end
        check("sat_254", 64'(err_cnt), 64'd254);
        xfer(1'b0, 16'h0000, 32'h0, 0, 1'b1);
        tick();
        check("sat_255", 64'(err_cnt), 64'd255);
        xfer(1'b0, 16'h0000, 32'h0, 0, 1'b1);
        tick();
        check("sat_hold", 64'(err_cnt), 64'd255);

        // Final readback of the register written under back-pressure
        xfer(1'b0, 16'h0010, 32'h0, 0, 1'b0);
        check("final_lat", 64'(lat), 64'd3);
        check("final_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 16, PADDR/cmd_addr width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles with PREADY low before abort.
REQ-004 SHALL have port PCLK, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port PRESETn, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in APB_ADDR_WIDTH, cmd_wdata in APB_DATA_WIDTH: request channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out APB_DATA_WIDTH, rsp_err out 1, rsp_timeout out 1: response channel.
REQ-008 SHALL have APB master ports PADDR out, PWRITE out, PSEL out, PENABLE out, PWDATA out, PRDATA in, PREADY in, PSLVERR in.
REQ-009 SHALL have port err_cnt, output, 8, saturating count of responses with rsp_err=1.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one outstanding transfer.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-012 On acceptance: register addr/write/wdata; next state SETUP.
REQ-013 SETUP: PSEL=1, PENABLE=0, lasts exactly one cycle, then ACCESS.
REQ-014 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA SHALL stay stable from SETUP to end of ACCESS.
REQ-015 PADDR[1:0] SHALL be driven 0 (word access); upper bits from cmd_addr.
REQ-016 PWDATA SHALL be driven 0 for reads.
REQ-017 ACCESS with PREADY=1: capture PRDATA (reads only; 0 on writes) and PSLVERR into the response; next state RESP; PSEL/PENABLE SHALL be 0 the following cycle.
REQ-018 Zero-wait-state slave: cmd accept at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid=1 in cycle N+3.
REQ-019 Wait-state counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-020 When the counter reaches TIMEOUT_CYCLES with PREADY still 0: abort, drop PSEL/PENABLE, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-021 PREADY=1 in the same cycle the counter reaches its limit SHALL complete normally (no timeout).
REQ-022 rsp_err SHALL equal captured PSLVERR, or 1 on timeout; rsp_timeout=1 only on timeout.
REQ-023 RESP: rsp_valid=1, response fields stable until rsp_valid&&rsp_ready; then IDLE.
REQ-024 Minimum 4 cycles per transfer; cmd_valid while not IDLE SHALL be ignored (held off by cmd_ready=0).
REQ-025 err_cnt SHALL increment by 1 on each response handshake with rsp_err=1; saturate at 255, never wrap.

Reset
REQ-026 On PRESETn=0 at a rising edge: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, err_cnt=0, wait counter=0.
REQ-027 Reset asserted mid-transfer SHALL abort it immediately at that edge; no response is produced for the aborted command.
REQ-028 cmd_ready SHALL be 1 in the first cycle after PRESETn returns to 1.

Structure
REQ-029 Shared package apb_pkg SHALL hold the FSM state enum, default width constants and the response struct (rdata, err, timeout).
REQ-030 One sub-module apb_wait_timer (clear, enable, expire at TIMEOUT_CYCLES) is natural; rest in apb_master_bridge.

Verification
REQ-031 Write 0x10 = 0x11223344 to apb_io_rw -> PSEL/PENABLE sequence per REQ-018, rsp_valid at N+3, rsp_err=0; readback of 0x10 gives 0x11223344.
REQ-032 Read 0x00 with status32b=0x9c4e9a31 -> rsp_rdata=0x9c4e9a31, rsp_err=0, PWDATA=0.
REQ-033 Slave stub holds PREADY=0 for 3 cycles with PSLVERR=1 at completion -> rsp_valid at N+6, rsp_err=1, rsp_timeout=0, err_cnt=1.
REQ-034 PREADY held 0 for 20 cycles, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 rsp_ready held 0 for 5 cycles with cmd_valid=1 throughout -> response fields stable, cmd_ready=0 until handshake, next command accepted in IDLE.
REQ-036 PRESETn pulsed 0 during ACCESS -> PSEL=PENABLE=0 next cycle, no rsp_valid, err_cnt=0, cmd_ready=1 after release.
